buffer_reader: RTL and testbench

- Read-side controller for the team's circular, parallel-port Buffer.
- Owns both ring pointers and occupancy: drives Buffer waddr/raddr and tells the writer how much space is free.
- Pops PAR_READ-wide windows from the Buffer read port into a registered valid/ready output stage, advancing by a run-time stride (sliding-window feed for the compute datapath).

---
 rtl/buffer_reader.sv | 235 +++++++++++++++++++++++
 tb/tb_buffer_reader.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/buffer_reader.sv
// buffer_reader: read-side controller for the circular, parallel-port Buffer.
// Owns the write/read ring pointers and the occupancy count, reports free
// space to the writer, and pops PAR_READ-wide windows from the Buffer read
// port into a registered valid/ready output stage, advancing by a run-time
// stride so the consumer sees a sliding window.
//
// Optional build macro BUFFER_READER_DRAIN_EN adds last_in, out_last and
// out_keep so a partial tail can be emitted once the writer marks its end.
// Without it, partial tails wait for more data or a flush.
module buffer_reader #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8,
    parameter int PAR_WRITE  = 1,
    parameter int PAR_READ   = 3,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           wr_commit,
    input  logic [$clog2(PAR_WRITE):0]     wr_count,
    output logic [ADDR_WIDTH-1:0]          waddr,
    output logic [ADDR_WIDTH:0]            space,
    output logic [ADDR_WIDTH-1:0]          raddr,
    input  logic [PAR_READ*DATA_WIDTH-1:0] buf_dout,
    input  logic [$clog2(PAR_READ):0]      stride,
    input  logic                           flush,
    output logic [PAR_READ*DATA_WIDTH-1:0] out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [ADDR_WIDTH:0]            count,
    output logic                           err_ovf
`ifdef BUFFER_READER_DRAIN_EN
    ,
    input  logic                           last_in,
    output logic                           out_last,
    output logic [PAR_READ-1:0]            out_keep
`endif
);

    localparam int  WC_W  = $clog2(PAR_WRITE) + 1;
    localparam int  ST_W  = $clog2(PAR_READ) + 1;
    localparam int  CNT_W = ADDR_WIDTH + 1;
    localparam int  SUM_W = CNT_W + WC_W + 1;
    localparam bit  POW2  = ((DEPTH & (DEPTH - 1)) == 0);

    // Advance a ring pointer by n entries, modulo DEPTH.
    function automatic logic [ADDR_WIDTH-1:0] ptr_add(
        input logic [ADDR_WIDTH-1:0] ptr,
        input logic [CNT_W-1:0]      n
    );
        logic [CNT_W-1:0] sum;
        sum = {1'b0, ptr} + n;
        if (POW2) begin
            return sum[ADDR_WIDTH-1:0];
        end else if (sum >= CNT_W'(DEPTH)) begin
            sum = sum - CNT_W'(DEPTH);
            return sum[ADDR_WIDTH-1:0];
        end else begin
            return sum[ADDR_WIDTH-1:0];
        end
    endfunction

    logic [ST_W-1:0]                s_eff_s;
    logic [SUM_W-1:0]               cnt_sum_s;
    logic                           ovf_s;
    logic                           commit_ok_s;
    logic                           hand_s;
    logic                           pop_s;
    logic [CNT_W-1:0]               add_s;
    logic                           drain_s;
    logic [PAR_READ*DATA_WIDTH-1:0] drain_data_s;

    logic [ADDR_WIDTH-1:0]          waddr_next_s;
    logic [ADDR_WIDTH-1:0]          raddr_next_s;
    logic [CNT_W-1:0]               count_next_s;
    logic                           out_valid_next_s;
    logic [PAR_READ*DATA_WIDTH-1:0] out_data_next_s;
    logic                           err_ovf_next_s;

`ifdef BUFFER_READER_DRAIN_EN
    logic                           drain_armed_r;
    logic                           drain_armed_next_s;
    logic [PAR_READ-1:0]            drain_keep_s;
    logic [PAR_READ-1:0]            out_keep_next_s;
    logic                           out_last_next_s;
`endif

    // Clamp the requested stride into 1..PAR_READ.
    always_comb begin
        s_eff_s = stride;
        if (stride == '0) begin
            s_eff_s = ST_W'(1);
        end else if (stride > ST_W'(PAR_READ)) begin
            s_eff_s = ST_W'(PAR_READ);
        end else begin
            s_eff_s = stride;
        end
    end

    // Commit qualification, overflow detection and pop decision.
    always_comb begin
        cnt_sum_s   = SUM_W'(count) + SUM_W'(wr_count);
        ovf_s       = wr_commit && (cnt_sum_s > SUM_W'(DEPTH));
        commit_ok_s = wr_commit && !ovf_s && !flush;
        hand_s      = !out_valid || out_ready;
        pop_s       = (count >= CNT_W'(PAR_READ)) && hand_s && !flush;
        if (commit_ok_s) begin
            add_s = CNT_W'(wr_count);
        end else begin
            add_s = '0;
        end
    end

`ifdef BUFFER_READER_DRAIN_EN
    // Build the masked tail window emitted when drain mode flushes a partial.
    always_comb begin
        drain_s      = drain_armed_r && (count != '0) &&
                       (count < CNT_W'(PAR_READ)) && hand_s && !flush;
        drain_data_s = '0;
        drain_keep_s = '0;
        for (int i = 0; i < PAR_READ; i++) begin
            if (CNT_W'(i) < count) begin
                drain_keep_s[i] = 1'b1;
                drain_data_s[i*DATA_WIDTH +: DATA_WIDTH] = buf_dout[i*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                drain_keep_s[i] = 1'b0;
                drain_data_s[i*DATA_WIDTH +: DATA_WIDTH] = '0;
            end
        end
    end
`else
    assign drain_s      = 1'b0;
    assign drain_data_s = '0;
`endif

    // Next-state for pointers, occupancy, output stage and error flag.
    always_comb begin
        waddr_next_s     = waddr;
        raddr_next_s     = raddr;
        count_next_s     = count;
        out_valid_next_s = out_valid;
        out_data_next_s  = out_data;
        err_ovf_next_s   = err_ovf;
`ifdef BUFFER_READER_DRAIN_EN
        drain_armed_next_s = drain_armed_r;
        out_keep_next_s    = out_keep;
        out_last_next_s    = out_last;
`endif
        if (flush) begin
            // Flush drops any concurrent commit and discards everything buffered.
            raddr_next_s     = waddr;
            count_next_s     = '0;
            out_valid_next_s = 1'b0;
            err_ovf_next_s   = 1'b0;
`ifdef BUFFER_READER_DRAIN_EN
            drain_armed_next_s = 1'b0;
`endif
        end else begin
            if (commit_ok_s) begin
                waddr_next_s = ptr_add(waddr, CNT_W'(wr_count));
            end else begin
                waddr_next_s = waddr;
            end
            if (ovf_s) begin
                err_ovf_next_s = 1'b1;
            end else begin
                err_ovf_next_s = err_ovf;
            end
            if (drain_s) begin
                // Tail window consumes everything up to the current write pointer.
                raddr_next_s     = waddr;
                count_next_s     = add_s;
                out_data_next_s  = drain_data_s;
                out_valid_next_s = 1'b1;
`ifdef BUFFER_READER_DRAIN_EN
                out_keep_next_s    = drain_keep_s;
                out_last_next_s    = 1'b1;
                drain_armed_next_s = last_in;
`endif
            end else if (pop_s) begin
                raddr_next_s     = ptr_add(raddr, CNT_W'(s_eff_s));
                count_next_s     = count + add_s - CNT_W'(s_eff_s);
                out_data_next_s  = buf_dout;
                out_valid_next_s = 1'b1;
`ifdef BUFFER_READER_DRAIN_EN
                out_keep_next_s    = {PAR_READ{1'b1}};
                out_last_next_s    = 1'b0;
                drain_armed_next_s = drain_armed_r || last_in;
`endif
            end else begin
                count_next_s = count + add_s;
                if (out_valid && out_ready) begin
                    out_valid_next_s = 1'b0;
                end else begin
                    out_valid_next_s = out_valid;
                end
`ifdef BUFFER_READER_DRAIN_EN
                drain_armed_next_s = drain_armed_r || last_in;
`endif
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            waddr     <= '0;
            raddr     <= '0;
            count     <= '0;
            space     <= CNT_W'(DEPTH);
            out_valid <= 1'b0;
            out_data  <= '0;
            err_ovf   <= 1'b0;
`ifdef BUFFER_READER_DRAIN_EN
            drain_armed_r <= 1'b0;
            out_keep      <= '0;
            out_last      <= 1'b0;
`endif
        end else begin
            waddr     <= waddr_next_s;
            raddr     <= raddr_next_s;
            count     <= count_next_s;
            space     <= CNT_W'(DEPTH) - count_next_s;
            out_valid <= out_valid_next_s;
            out_data  <= out_data_next_s;
            err_ovf   <= err_ovf_next_s;
`ifdef BUFFER_READER_DRAIN_EN
            drain_armed_r <= drain_armed_next_s;
            out_keep      <= out_keep_next_s;
            out_last      <= out_last_next_s;
`endif
        end
    end

endmodule

// File: tb/tb_buffer_reader.sv
// Directed testbench for buffer_reader (DEPTH=8, PAR_READ=3, PAR_WRITE=1).
// A small behavioural Buffer (registered write, combinational read) sits
// between the writer side of the bench and the DUT read port.
// Build with BUFFER_READER_DRAIN_EN defined to exercise the tail-drain path.
module tb_buffer_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_commit;
    logic [0:0]  wr_count;
    logic [2:0]  waddr;
    logic [3:0]  space;
    logic [2:0]  raddr;
    logic [47:0] buf_dout;
    logic [2:0]  stride;
    logic        flush;
    logic [47:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  count;
    logic        err_ovf;
    logic [15:0] wr_data;
`ifdef BUFFER_READER_DRAIN_EN
    logic        last_in;
    logic        out_last;
    logic [2:0]  out_keep;
`endif

    int vectors = 0;
    int errors  = 0;

    logic [15:0] mem [0:7];

    buffer_reader #(
        .DATA_WIDTH(16), .DEPTH(8), .PAR_WRITE(1), .PAR_READ(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .wr_commit(wr_commit), .wr_count(wr_count),
        .waddr(waddr), .space(space), .raddr(raddr), .buf_dout(buf_dout),
        .stride(stride), .flush(flush), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .count(count), .err_ovf(err_ovf)
`ifdef BUFFER_READER_DRAIN_EN
        , .last_in(last_in), .out_last(out_last), .out_keep(out_keep)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural Buffer: write at waddr on commit, combinational windowed read.
    always @(posedge clk) begin
        if (wr_commit) mem[waddr] <= wr_data;
    end

    always_comb begin
        buf_dout = '0;
        for (int i = 0; i < 3; i++) buf_dout[i*16 +: 16] = mem[(int'(raddr) + i) % 8];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic commit(input logic [15:0] d);
        wr_commit = 1'b1;
        wr_data   = d;
        step();
        wr_commit = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        vectors++; if (waddr !== 3'd0) begin errors++; $display("FAIL rst_waddr: got %0d expected 0", waddr); end
        vectors++; if (raddr !== 3'd0) begin errors++; $display("FAIL rst_raddr: got %0d expected 0", raddr); end
        vectors++; if (count !== 4'd0) begin errors++; $display("FAIL rst_count: got %0d expected 0", count); end
        vectors++; if (space !== 4'd8) begin errors++; $display("FAIL rst_space: got %0d expected 8", space); end
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", out_valid); end
        vectors++; if (err_ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b expected 0", err_ovf); end
        vectors++; if (out_data !== 48'h0) begin errors++; $display("FAIL rst_data: got %h expected 0", out_data); end
        rst_n = 1'b1;
    endtask

    task automatic test_sliding();
        stride = 3'd1; out_ready = 1'b1;
        commit(16'h0011);
        commit(16'h0012);
        commit(16'h0013);
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL slide_early_valid: got %b expected 0", out_valid); end
        vectors++; if (count !== 4'd3) begin errors++; $display("FAIL slide_count3: got %0d expected 3", count); end
        commit(16'h0014);
        vectors++; if (out_valid !== 1'b1) begin errors++; $display("FAIL slide_valid1: got %b expected 1", out_valid); end
        vectors++; if (out_data !== 48'h0013_0012_0011) begin errors++; $display("FAIL slide_win1: got %h expected 001300120011", out_data); end
        vectors++; if (raddr !== 3'd1) begin errors++; $display("FAIL slide_raddr1: got %0d expected 1", raddr); end
`ifdef BUFFER_READER_DRAIN_EN
        vectors++; if (out_keep !== 3'b111) begin errors++; $display("FAIL slide_keep: got %b expected 111", out_keep); end
        vectors++; if (out_last !== 1'b0) begin errors++; $display("FAIL slide_last: got %b expected 0", out_last); end
`endif
        commit(16'h0015);
        vectors++; if (out_data !== 48'h0014_0013_0012) begin errors++; $display("FAIL slide_win2: got %h expected 001400130012", out_data); end
        step();
        vectors++; if (out_data !== 48'h0015_0014_0013) begin errors++; $display("FAIL slide_win3: got %h expected 001500140013", out_data); end
        vectors++; if (count !== 4'd2) begin errors++; $display("FAIL slide_count2: got %0d expected 2", count); end
        vectors++; if (raddr !== 3'd3) begin errors++; $display("FAIL slide_raddr3: got %0d expected 3", raddr); end
        step();
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL slide_drain_valid: got %b expected 0", out_valid); end
        vectors++; if (waddr !== 3'd5) begin errors++; $display("FAIL slide_waddr: got %0d expected 5", waddr); end
    endtask

    task automatic test_wrap();
        stride = 3'd3; out_ready = 1'b1;
        commit(16'h0016);
        vectors++; if (count !== 4'd3) begin errors++; $display("FAIL wrap_pre_count: got %0d expected 3", count); end
        step();
        vectors++; if (out_data !== 48'h0016_0015_0014) begin errors++; $display("FAIL wrap_pre_win: got %h expected 001600150014", out_data); end
        vectors++; if (raddr !== 3'd6) begin errors++; $display("FAIL wrap_pre_raddr: got %0d expected 6", raddr); end
        out_ready = 1'b0;
        commit(16'h0026);
        commit(16'h0027);
        commit(16'h0020);
        commit(16'h0021);
        commit(16'h0022);
        vectors++; if (count !== 4'd5) begin errors++; $display("FAIL wrap_count5: got %0d expected 5", count); end
        vectors++; if (waddr !== 3'd3) begin errors++; $display("FAIL wrap_waddr3: got %0d expected 3", waddr); end
        vectors++; if (out_data !== 48'h0016_0015_0014) begin errors++; $display("FAIL wrap_hold: got %h expected 001600150014", out_data); end
        out_ready = 1'b1;
        step();
        vectors++; if (out_data !== 48'h0020_0027_0026) begin errors++; $display("FAIL wrap_win: got %h expected 002000270026", out_data); end
        vectors++; if (raddr !== 3'd1) begin errors++; $display("FAIL wrap_raddr: got %0d expected 1", raddr); end
        vectors++; if (count !== 4'd2) begin errors++; $display("FAIL wrap_count2: got %0d expected 2", count); end
        step();
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL wrap_drain_valid: got %b expected 0", out_valid); end
    endtask

    task automatic test_full_overflow();
        out_ready = 1'b0;
        commit(16'h0030);
        commit(16'h0031);
        vectors++; if (out_data !== 48'h0030_0022_0021) begin errors++; $display("FAIL full_win: got %h expected 003000220021", out_data); end
        vectors++; if (count !== 4'd1) begin errors++; $display("FAIL full_count1: got %0d expected 1", count); end
        for (int k = 0; k < 7; k++) commit(16'h0032 + 16'(k));
        vectors++; if (count !== 4'd8) begin errors++; $display("FAIL full_count8: got %0d expected 8", count); end
        vectors++; if (space !== 4'd0) begin errors++; $display("FAIL full_space: got %0d expected 0", space); end
        vectors++; if (waddr !== 3'd4) begin errors++; $display("FAIL full_waddr: got %0d expected 4", waddr); end
        vectors++; if (out_data !== 48'h0030_0022_0021) begin errors++; $display("FAIL full_hold: got %h expected 003000220021", out_data); end
        commit(16'h0039);
        vectors++; if (err_ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", err_ovf); end
        vectors++; if (count !== 4'd8) begin errors++; $display("FAIL ovf_count: got %0d expected 8", count); end
        vectors++; if (waddr !== 3'd4) begin errors++; $display("FAIL ovf_waddr: got %0d expected 4", waddr); end
        step();
        vectors++; if (err_ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", err_ovf); end
        flush = 1'b1;
        step();
        flush = 1'b0;
        vectors++; if (count !== 4'd0) begin errors++; $display("FAIL flush_count: got %0d expected 0", count); end
        vectors++; if (raddr !== 3'd4) begin errors++; $display("FAIL flush_raddr: got %0d expected 4", raddr); end
        vectors++; if (err_ovf !== 1'b0) begin errors++; $display("FAIL flush_ovf: got %b expected 0", err_ovf); end
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b expected 0", out_valid); end
        vectors++; if (space !== 4'd8) begin errors++; $display("FAIL flush_space: got %0d expected 8", space); end
    endtask

    task automatic test_flush_commit();
        stride = 3'd1; out_ready = 1'b0;
        commit(16'h0041);
        commit(16'h0042);
        commit(16'h0043);
        commit(16'h0044);
        vectors++; if (out_data !== 48'h0043_0042_0041) begin errors++; $display("FAIL fc_win: got %h expected 004300420041", out_data); end
        vectors++; if (waddr !== 3'd0) begin errors++; $display("FAIL fc_pre_waddr: got %0d expected 0", waddr); end
        out_ready = 1'b1; flush = 1'b1; wr_commit = 1'b1; wr_data = 16'h0045;
        step();
        flush = 1'b0; wr_commit = 1'b0;
        vectors++; if (waddr !== 3'd0) begin errors++; $display("FAIL fc_waddr: got %0d expected 0", waddr); end
        vectors++; if (count !== 4'd0) begin errors++; $display("FAIL fc_count: got %0d expected 0", count); end
        vectors++; if (raddr !== 3'd0) begin errors++; $display("FAIL fc_raddr: got %0d expected 0", raddr); end
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fc_valid: got %b expected 0", out_valid); end
        step();
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fc_idle_valid: got %b expected 0", out_valid); end
    endtask

    task automatic test_stride_clamp();
        stride = 3'd0; out_ready = 1'b1;
        commit(16'h0051);
        commit(16'h0052);
        commit(16'h0053);
        commit(16'h0054);
        vectors++; if (raddr !== 3'd1) begin errors++; $display("FAIL stride0_raddr: got %0d expected 1", raddr); end
        vectors++; if (out_data !== 48'h0053_0052_0051) begin errors++; $display("FAIL stride0_win: got %h expected 005300520051", out_data); end
        stride = 3'd7;
        step();
        vectors++; if (raddr !== 3'd4) begin errors++; $display("FAIL stride7_raddr: got %0d expected 4", raddr); end
        vectors++; if (count !== 4'd0) begin errors++; $display("FAIL stride7_count: got %0d expected 0", count); end
        vectors++; if (out_data !== 48'h0054_0053_0052) begin errors++; $display("FAIL stride7_win: got %h expected 005400530052", out_data); end
        step();
    endtask

    task automatic test_drain();
        stride = 3'd1; out_ready = 1'b1;
        commit(16'h00A1);
        commit(16'h00A2);
        vectors++; if (count !== 4'd2) begin errors++; $display("FAIL tail_count: got %0d expected 2", count); end
`ifdef BUFFER_READER_DRAIN_EN
        last_in = 1'b1;
        step();
        last_in = 1'b0;
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_arm_valid: got %b expected 0", out_valid); end
        step();
        vectors++; if (out_valid !== 1'b1) begin errors++; $display("FAIL drain_valid: got %b expected 1", out_valid); end
        vectors++; if (out_data !== 48'h0000_00A2_00A1) begin errors++; $display("FAIL drain_win: got %h expected 000000a200a1", out_data); end
        vectors++; if (out_keep !== 3'b011) begin errors++; $display("FAIL drain_keep: got %b expected 011", out_keep); end
        vectors++; if (out_last !== 1'b1) begin errors++; $display("FAIL drain_last: got %b expected 1", out_last); end
        vectors++; if (count !== 4'd0) begin errors++; $display("FAIL drain_count: got %0d expected 0", count); end
        vectors++; if (raddr !== 3'd6) begin errors++; $display("FAIL drain_raddr: got %0d expected 6", raddr); end
        step();
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_after_valid: got %b expected 0", out_valid); end
`else
        step();
        step();
        step();
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL tail_valid: got %b expected 0", out_valid); end
        vectors++; if (count !== 4'd2) begin errors++; $display("FAIL tail_hold_count: got %0d expected 2", count); end
        vectors++; if (raddr !== 3'd4) begin errors++; $display("FAIL tail_raddr: got %0d expected 4", raddr); end
`endif
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = 16'h0;
        rst_n = 1'b0; wr_commit = 1'b0; wr_count = 1'b1; wr_data = 16'h0;
        stride = 3'd1; flush = 1'b0; out_ready = 1'b0;
`ifdef BUFFER_READER_DRAIN_EN
        last_in = 1'b0;
`endif
        test_reset();
        test_sliding();
        test_wrap();
        test_full_overflow();
        test_flush_commit();
        test_stride_clamp();
        test_drain();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
